// File: rtl/main_memory_responder_pkg.sv
// rtl/main_memory_responder_pkg.sv - shared types and constants for the main-memory responder
package main_memory_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LAT,
    RD_STREAM,
    RD_DONE,
    WR_LAT,
    WR_DONE
  } mm_state_t;

  localparam int BLOCK_OFFSET_W    = 4;
  localparam int DEF_READ_LATENCY  = 4;
  localparam int DEF_WRITE_LATENCY = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// rtl/main_memory_responder_if.sv - L2-to-main-memory word interface
interface main_memory_responder_if #(
  parameter int n      = 32,
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] MM_word_address;
  logic [n-1:0]      MM_write_word;
  logic              MM_read_request;
  logic              MM_write_request;
  logic [n-1:0]      MM_read_word;
  logic              MM_busy;

  // L2 side drives requests and consumes burst data
  modport master (
    output MM_word_address, MM_write_word, MM_read_request, MM_write_request,
    input  MM_read_word, MM_busy
  );

  // memory side answers requests
  modport slave (
    input  MM_word_address, MM_write_word, MM_read_request, MM_write_request,
    output MM_read_word, MM_busy
  );
endinterface

// File: rtl/main_memory_responder_storage.sv
// rtl/main_memory_responder_storage.sv - single-port synchronous RAM with registered read data
module main_memory_responder_storage #(
  parameter int n      = 32,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [n-1:0]      i_wdata,
  output logic [n-1:0]      o_rdata
);
  logic [n-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [n-1:0] r_rdata;

  // storage array write port; contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // read data register: cleared by reset, holds its value when no read is issued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - block-refill / write-through responder; MM_STATS_EN adds activity counters
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int n             = 32,
  parameter int ADDR_W        = 15,
  parameter int block_size    = 16,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  main_memory_responder_if.slave  mm
`ifdef MM_STATS_EN
  ,
  output logic [11:0]             o_rd_burst_count,
  output logic [11:0]             o_wr_count,
  output logic [15:0]             o_stall_count
`endif
);
  localparam int OFF_W  = $clog2(block_size);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int LAT_W  = $clog2(max_int(READ_LATENCY, WRITE_LATENCY)) + 1;
  localparam int BEAT_W = $clog2(block_size) + 1;

  mm_state_t         r_state, w_next;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_next;
  logic [BEAT_W-1:0] r_beat, w_beat_next, w_beat_inc;
  logic [IDX_W-1:0]  r_base_idx, w_base_next;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next, w_mem_addr;
  logic [n-1:0]      r_wr_data, w_wr_data_next, w_mem_wdata, w_rdata;
  logic              w_busy, w_mem_en, w_mem_we, w_burst_done, w_wr_commit;

  assign w_beat_inc = r_beat + BEAT_W'(1);

  // state, counters and latched request fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_beat     <= '0;
      r_base_idx <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_lat_cnt  <= w_lat_next;
      r_beat     <= w_beat_next;
      r_base_idx <= w_base_next;
      r_wr_addr  <= w_wr_addr_next;
      r_wr_data  <= w_wr_data_next;
    end
  end

  // next state, busy decode and RAM port control; the RAM read for beat k is
  // issued one cycle early so the registered data lines up with beat k
  always_comb begin
    w_next         = r_state;
    w_lat_next     = r_lat_cnt;
    w_beat_next    = r_beat;
    w_base_next    = r_base_idx;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_busy         = 1'b0;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = r_wr_addr;
    w_mem_wdata    = r_wr_data;
    w_burst_done   = 1'b0;
    w_wr_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mm.MM_write_request) begin
          // write wins so a write-through store is never overtaken by a refill
          w_busy         = 1'b1;
          w_wr_addr_next = mm.MM_word_address;
          w_wr_data_next = mm.MM_write_word;
          if (WRITE_LATENCY == 1) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = mm.MM_word_address;
            w_mem_wdata = mm.MM_write_word;
            w_wr_commit = 1'b1;
            w_next      = WR_DONE;
          end else begin
            w_lat_next = LAT_W'(WRITE_LATENCY - 1);
            w_next     = WR_LAT;
          end
        end else if (mm.MM_read_request) begin
          w_busy      = 1'b1;
          w_base_next = mm.MM_word_address[ADDR_W-1:OFF_W];
          w_beat_next = '0;
          if (READ_LATENCY == 1) begin
            w_mem_en   = 1'b1;
            w_mem_addr = {mm.MM_word_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            w_next     = RD_STREAM;
          end else begin
            w_lat_next = LAT_W'(READ_LATENCY - 1);
            w_next     = RD_LAT;
          end
        end
      end
      RD_LAT: begin
        w_busy = 1'b1;
        if (!mm.MM_read_request) begin
          w_next = IDLE;
        end else if (r_lat_cnt <= LAT_W'(1)) begin
          w_mem_en    = 1'b1;
          w_mem_addr  = {r_base_idx, {OFF_W{1'b0}}};
          w_lat_next  = '0;
          w_beat_next = '0;
          w_next      = RD_STREAM;
        end else begin
          w_lat_next = r_lat_cnt - LAT_W'(1);
        end
      end
      RD_STREAM: begin
        if (!mm.MM_read_request) begin
          w_next = IDLE;
        end else if (r_beat == BEAT_W'(block_size - 1)) begin
          w_burst_done = 1'b1;
          w_next       = RD_DONE;
        end else begin
          // offset wraps inside the block: base index bits are never touched
          w_beat_next = w_beat_inc;
          w_mem_en    = 1'b1;
          w_mem_addr  = {r_base_idx, w_beat_inc[OFF_W-1:0]};
        end
      end
      RD_DONE: begin
        if (!mm.MM_read_request) w_next = IDLE;
      end
      WR_LAT: begin
        // the write commits even if the request has already been dropped
        w_busy = 1'b1;
        if (r_lat_cnt <= LAT_W'(1)) begin
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_wr_commit = 1'b1;
          w_lat_next  = '0;
          w_next      = WR_DONE;
        end else begin
          w_lat_next = r_lat_cnt - LAT_W'(1);
        end
      end
      WR_DONE: begin
        if (!mm.MM_write_request) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  main_memory_responder_storage #(.n(n), .ADDR_W(ADDR_W)) u_storage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

  assign mm.MM_read_word = w_rdata;
  assign mm.MM_busy      = w_busy;

`ifdef MM_STATS_EN
  logic [11:0] r_rd_cnt, r_wr_cnt;
  logic [15:0] r_stall_cnt;

  // saturating activity counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_burst_done && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 12'd1;
      if (w_wr_commit && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 12'd1;
      if (w_busy && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_rd_burst_count = r_rd_cnt;
  assign o_wr_count       = r_wr_cnt;
  assign o_stall_count    = r_stall_cnt;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - directed self-checking bench for main_memory_responder
module tb_main_memory_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_a [16];
  logic [31:0] exp_b [16];
  logic [31:0] exp_c [16];

  main_memory_responder_if #(.n(32), .ADDR_W(15)) mm_bus ();

`ifdef MM_STATS_EN
  logic [11:0] rd_cnt, wr_cnt;
  logic [15:0] st_cnt;
`endif

  main_memory_responder #(
    .n(32), .ADDR_W(15), .block_size(16), .READ_LATENCY(4), .WRITE_LATENCY(2)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .mm      (mm_bus)
`ifdef MM_STATS_EN
    ,
    .o_rd_burst_count (rd_cnt),
    .o_wr_count       (wr_cnt),
    .o_stall_count    (st_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] d);
    mm_bus.MM_word_address  = a;
    mm_bus.MM_write_word    = d;
    mm_bus.MM_write_request = 1'b1;
    #1;
    check("wr_idle_busy", 32'(mm_bus.MM_busy), 32'd1);
    tick(); #1;
    check("wr_lat_busy", 32'(mm_bus.MM_busy), 32'd1);
    tick(); #1;
    check("wr_done_busy", 32'(mm_bus.MM_busy), 32'd0);
    mm_bus.MM_write_request = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [14:0] a, input logic [31:0] exp [16], input string tag);
    mm_bus.MM_word_address = a;
    mm_bus.MM_read_request = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lat_busy%0d", tag, i), 32'(mm_bus.MM_busy), 32'd1);
      tick(); #1;
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_beat%0d_busy", tag, k), 32'(mm_bus.MM_busy), 32'd0);
      check($sformatf("%s_beat%0d", tag, k), mm_bus.MM_read_word, exp[k]);
      tick(); #1;
    end
    check($sformatf("%s_done_busy", tag), 32'(mm_bus.MM_busy), 32'd0);
    check($sformatf("%s_done_hold", tag), mm_bus.MM_read_word, exp[15]);
    mm_bus.MM_read_request = 1'b0;
    tick();
  endtask

  initial begin
    mm_bus.MM_read_request  = 1'b0;
    mm_bus.MM_write_request = 1'b0;
    mm_bus.MM_word_address  = '0;
    mm_bus.MM_write_word    = '0;
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = 32'(32'hA0 + i);
      exp_b[i] = (i == 15) ? 32'hDEAD_BEEF : 32'(32'h7FF0_0000 + i);
      exp_c[i] = 32'(32'h0B00 + i);
    end

    tick();
    check("reset_busy", 32'(mm_bus.MM_busy), 32'd0);
    check("reset_word", mm_bus.MM_read_word, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) do_write(15'(15'h120 + i), exp_a[i]);
    do_read(15'h125, exp_a, "blk120");

    for (int i = 0; i < 15; i++) do_write(15'(15'h7FF0 + i), exp_b[i]);
    do_write(15'h7FFF, 32'hDEAD_BEEF);
    do_read(15'h7FF0, exp_b, "blk7ff0");

    for (int i = 0; i < 16; i++) do_write(15'(15'h200 + i), exp_c[i]);

    // read and write together: write first, then the burst sees the new value
    mm_bus.MM_word_address  = 15'h040;
    mm_bus.MM_write_word    = 32'h1234_5678;
    mm_bus.MM_write_request = 1'b1;
    mm_bus.MM_read_request  = 1'b1;
    #1;
    check("both_idle_busy", 32'(mm_bus.MM_busy), 32'd1);
    tick(); #1;
    check("both_wr_lat_busy", 32'(mm_bus.MM_busy), 32'd1);
    tick(); #1;
    check("both_wr_done_busy", 32'(mm_bus.MM_busy), 32'd0);
    mm_bus.MM_write_request = 1'b0;
    tick(); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("both_rd_busy%0d", i), 32'(mm_bus.MM_busy), 32'd1);
      tick(); #1;
    end
    check("both_beat0_busy", 32'(mm_bus.MM_busy), 32'd0);
    check("both_beat0", mm_bus.MM_read_word, 32'h1234_5678);
    mm_bus.MM_read_request = 1'b0;
    tick(); #1;
    check("both_abort_idle", 32'(mm_bus.MM_busy), 32'd0);

    // drop the read at beat 5, then a fresh read must start from scratch
    mm_bus.MM_word_address = 15'h125;
    mm_bus.MM_read_request = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_lat_busy%0d", i), 32'(mm_bus.MM_busy), 32'd1);
      tick(); #1;
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_beat%0d", k), mm_bus.MM_read_word, exp_a[k]);
      if (k != 5) begin
        tick(); #1;
      end
    end
    mm_bus.MM_read_request = 1'b0;
    tick(); #1;
    check("abort_idle_busy", 32'(mm_bus.MM_busy), 32'd0);
    check("abort_idle_hold", mm_bus.MM_read_word, exp_a[5]);
    do_read(15'h200, exp_c, "blk200");

    // reset during WR_LAT: write to 0x121 must be lost
    mm_bus.MM_word_address  = 15'h121;
    mm_bus.MM_write_word    = 32'h0000_0055;
    mm_bus.MM_write_request = 1'b1;
    #1;
    check("rstwr_idle_busy", 32'(mm_bus.MM_busy), 32'd1);
    tick(); #1;
    check("rstwr_lat_busy", 32'(mm_bus.MM_busy), 32'd1);
    rst_n = 1'b0;
    mm_bus.MM_write_request = 1'b0;
    #1;
    check("rstwr_busy", 32'(mm_bus.MM_busy), 32'd0);
    check("rstwr_word", mm_bus.MM_read_word, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // after reset: 3 bursts and 2 writes
    do_read(15'h125, exp_a, "post_rst");
    do_write(15'h300, 32'h0000_0001);
    do_write(15'h301, 32'h0000_0002);
    do_read(15'h120, exp_a, "again120");
    do_read(15'h200, exp_c, "again200");
`ifdef MM_STATS_EN
    check("stats_rd", 32'(rd_cnt), 32'd3);
    check("stats_wr", 32'(wr_cnt), 32'd2);
    check("stats_stall", 32'(st_cnt), 32'd16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
